id_operand_stage: RTL and testbench
===================================

# id_operand_stage

Decode/operand-fetch stage of the five-stage pipeline. It sits between instruction fetch and execute and drives the register file's two read ports. It resolves read-after-write hazards by forwarding from EX, MEM and WB, and inserts load-use bubbles. It produces the registered ID/EX pipeline word consumed by the execute stage.

## Interface
- No parameters; data width 32, register address width 5 (fixed by ISA).
- clk  in  1  clock; all state updates on posedge.
- nrst  in  1  reset, synchronous, active-low.
- if_valid  in  1  fetch presents a valid instruction.
- if_instr  in  32  instruction word (MIPS encoding).
- if_pc  in  32  PC of if_instr.
- id_stall  out  1  combinational; IF must hold if_instr/if_pc this cycle.
- rf_rd_addrA / rf_rd_addrB  out  5  combinational; equal to instr[25:21] (rs) / instr[20:16] (rt).
- rf_rd_dataA / rf_rd_dataB  in  32  register file read data, combinational; the register file writes on posedge.
- ex_wr_en, ex_is_load  in  1  EX-stage instruction writes a register / is a load.
- ex_wr_addr  in  5; ex_fwd_data  in  32  EX result, valid when ex_wr_en & !ex_is_load.
- mem_wr_en  in  1; mem_wr_addr  in  5; mem_wr_data  in  32.
- wb_wr_en  in  1; wb_wr_addr  in  5; wb_wr_data  in  32  same signals that drive the register file write port.
- ex_hold  in  1  execute cannot accept; ID/EX must hold.
- flush  in  1  branch/jump redirect; kill the instruction in ID.
- idex_valid  out  1; idex_pc  out  32; idex_opcode  out  6; idex_funct  out  6.
- idex_opA / idex_opB  out  32  resolved rs / rt values; idex_imm  out  32.
- idex_wr_en  out  1; idex_wr_addr  out  5; idex_is_load  out  1.

## Operation
- **Source use.**
  - use_rs = 1 except for opcodes LUI 0x0F, J 0x02 and JAL 0x03.
  - use_rt = 1 for R-type 0x00, SW 0x2B, BEQ 0x04 and BNE 0x05.
- **Destination.**
  - R-type: rd (instr[15:11]). wr_en = 0 when funct = JR 0x08 or instr = 0 (NOP).
  - I-type ALU (0x08–0x0F) and LW 0x23: rt.
  - JAL: address 31.
  - All other instructions: wr_en = 0.
- **Immediate.**
  - ANDI/ORI/XORI (0x0C/0x0D/0x0E): zero-extended instr[15:0].
  - LUI: {instr[15:0], 16'h0}.
  - Otherwise: sign-extended instr[15:0].
- **Operand resolution, per operand, first match wins.**
  1. Address 0 gives 0, regardless of register file content.
  2. ex_wr_en & !ex_is_load & addr match gives ex_fwd_data.
  3. mem_wr_en & match gives mem_wr_data.
  4. wb_wr_en & match gives wb_wr_data, which covers the same-cycle register file write.
  5. Otherwise, rf data.
- **Load-use hazard** = if_valid & ex_wr_en & ex_is_load & ex_wr_addr != 0 & ((use_rs & rs match) | (use_rt & rt match)).
- **id_stall** = !flush & (ex_hold | load_use).
- **ID/EX update at each posedge, priority order:**
  1. !nrst: all idex outputs cleared to 0.
  2. flush: idex_valid <= 0; other fields don't-care (set to 0).
  3. ex_hold: all idex fields hold.
  4. load_use: bubble; idex_valid <= 0, idex_wr_en <= 0.
  5. Else: load the decoded word; idex_valid <= if_valid; idex_wr_en <= decoded wr_en & if_valid.
- idex_is_load <= (opcode == LW) & if_valid; it is 0 in any bubble.

## Timing
- Latency is 1 cycle: an instruction presented at cycle N appears on idex_* after the posedge ending N.
- rf_rd_addr*, id_stall and operand muxes are combinational from inputs. There are no combinational paths from ex_*/mem_*/wb_* to idex_* outputs.
- A load-use stall lasts exactly 1 cycle: after the bubble, the load is in MEM and is forwarded from the mem_* inputs.
- flush coincident with ex_hold or load_use: flush wins; idex_valid = 0 and id_stall = 0.
- nrst asserted mid-stall: the next posedge clears all state; no bubble or hold survives.
- All outputs read 0 after reset.

## Structure
- cpu_pkg holds opcode/funct constants (OP_RTYPE, OP_LW, OP_SW, OP_LUI, OP_JAL, FN_JR, ...) and REG_RA = 31.
- Sub-module fwd_mux (addr, rf_data, EX/MEM/WB triples → operand), instantiated once for rs and once for rt.
- Decode logic and the ID/EX register live in id_operand_stage.

## Test plan
- **Plain R-type with no hazards:** ADD r3,r1,r2 with rf r1=5, r2=7 → next cycle idex_opA=5, opB=7, wr_addr=3, wr_en=1, valid=1.
- **Forward priority:** rs=r4 with EX (non-load) =0xAA, MEM =0xBB and WB =0xCC all targeting r4 → opA=0xAA. Drop EX → 0xBB. Drop MEM → 0xCC.
- **Load-use:** ex LW writing r8, ID holds ADDI r9,r8,1 → id_stall=1 for one cycle and an idex_valid=0 bubble. Next cycle mem_wr_data=0x10 → opA=0x10, imm=1.
- **Register zero:** rs=0 with wb_wr_en to r0 data 0xFFFF → opA=0. LUI 0x1234 with rs match on a load → no stall, imm=0x12340000.
- **Flush vs hold:** flush=1 with ex_hold=1 → idex_valid=0 next cycle, id_stall=0. ex_hold alone for 3 cycles → idex_* unchanged, id_stall=1.
- **Reset mid-stall:** nrst low during a load-use stall → all idex outputs 0 next edge. The next instruction after release is decoded normally.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared ISA constants and the ID/EX pipeline word for the
//                five-stage MIPS-style pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

   localparam int DATA_W = 32;
   localparam int REG_W  = 5;

   // Primary opcodes (instr[31:26])
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // R-type function codes (instr[5:0])
   localparam logic [5:0] FN_JR    = 6'h08;

   // Link register written by JAL
   localparam logic [REG_W-1:0] REG_RA = 5'd31;

   // Registered word handed from decode to execute
   typedef struct packed {
      logic              valid;
      logic [DATA_W-1:0] pc;
      logic [5:0]        opcode;
      logic [5:0]        funct;
      logic [DATA_W-1:0] opA;
      logic [DATA_W-1:0] opB;
      logic [DATA_W-1:0] imm;
      logic              wr_en;
      logic [REG_W-1:0]  wr_addr;
      logic              is_load;
   } idex_word_t;

   // I-type ALU opcodes occupy 0x08..0x0F
   function automatic logic is_itype_alu(input logic [5:0] op);
      return (op[5:3] == 3'b001);
   endfunction

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/id_operand_stage_fwd_mux.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_mux
//  Description : Resolves one source operand from the register file or the
//                EX / MEM / WB bypass paths; nearest producer wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_mux
   import cpu_pkg::*;
(
   input  logic [REG_W-1:0]  addr,
   input  logic [DATA_W-1:0] rf_data,
   input  logic              ex_en,
   input  logic [REG_W-1:0]  ex_addr,
   input  logic [DATA_W-1:0] ex_data,
   input  logic              mem_en,
   input  logic [REG_W-1:0]  mem_addr,
   input  logic [DATA_W-1:0] mem_data,
   input  logic              wb_en,
   input  logic [REG_W-1:0]  wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic [DATA_W-1:0] operand
);

   // Priority select: r0 is hardwired zero, then youngest in-flight producer first
   always_comb begin
      operand = rf_data;
      if (addr == '0)
         operand = '0;
      else if (ex_en && (ex_addr == addr))
         operand = ex_data;
      else if (mem_en && (mem_addr == addr))
         operand = mem_data;
      else if (wb_en && (wb_addr == addr))
         operand = wb_data;  // also covers the register file write landing this cycle
   end

endmodule : fwd_mux
`default_nettype wire

// File: rtl/id_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_operand_stage
//  Description : Decode / operand-fetch stage. Drives the register file read
//                ports, forwards from EX/MEM/WB, inserts load-use bubbles and
//                registers the ID/EX pipeline word.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_operand_stage
   import cpu_pkg::*;
(
   input  logic              clk,
   input  logic              nrst,
   input  logic              if_valid,
   input  logic [31:0]       if_instr,
   input  logic [31:0]       if_pc,
   output logic              id_stall,
   output logic [4:0]        rf_rd_addrA,
   output logic [4:0]        rf_rd_addrB,
   input  logic [31:0]       rf_rd_dataA,
   input  logic [31:0]       rf_rd_dataB,
   input  logic              ex_wr_en,
   input  logic              ex_is_load,
   input  logic [4:0]        ex_wr_addr,
   input  logic [31:0]       ex_fwd_data,
   input  logic              mem_wr_en,
   input  logic [4:0]        mem_wr_addr,
   input  logic [31:0]       mem_wr_data,
   input  logic              wb_wr_en,
   input  logic [4:0]        wb_wr_addr,
   input  logic [31:0]       wb_wr_data,
   input  logic              ex_hold,
   input  logic              flush,
   output logic              idex_valid,
   output logic [31:0]       idex_pc,
   output logic [5:0]        idex_opcode,
   output logic [5:0]        idex_funct,
   output logic [31:0]       idex_opA,
   output logic [31:0]       idex_opB,
   output logic [31:0]       idex_imm,
   output logic              idex_wr_en,
   output logic [4:0]        idex_wr_addr,
   output logic              idex_is_load
);

   // Instruction fields
   logic [5:0]        w_opcode;
   logic [5:0]        w_funct;
   logic [REG_W-1:0]  w_rs;
   logic [REG_W-1:0]  w_rt;
   logic [REG_W-1:0]  w_rd;
   logic [15:0]       w_imm16;

   assign w_opcode = if_instr[31:26];
   assign w_rs     = if_instr[25:21];
   assign w_rt     = if_instr[20:16];
   assign w_rd     = if_instr[15:11];
   assign w_funct  = if_instr[5:0];
   assign w_imm16  = if_instr[15:0];

   assign rf_rd_addrA = w_rs;
   assign rf_rd_addrB = w_rt;

   logic              w_use_rs;
   logic              w_use_rt;
   logic              w_dec_wr_en;
   logic [REG_W-1:0]  w_dec_wr_addr;
   logic [DATA_W-1:0] w_dec_imm;
   logic              w_ex_fwd_en;
   logic              w_load_use;
   logic [DATA_W-1:0] w_opA;
   logic [DATA_W-1:0] w_opB;
   idex_word_t        w_dec;
   idex_word_t        r_idex;

   // Which source registers the instruction actually reads
   always_comb begin
      w_use_rs = !((w_opcode == OP_LUI) || (w_opcode == OP_J) || (w_opcode == OP_JAL));
      w_use_rt = (w_opcode == OP_RTYPE) || (w_opcode == OP_SW) ||
                 (w_opcode == OP_BEQ)   || (w_opcode == OP_BNE);
   end

   // Destination register; address forced to 0 when nothing is written
   always_comb begin
      w_dec_wr_en   = 1'b0;
      w_dec_wr_addr = '0;
      if (w_opcode == OP_RTYPE) begin
         w_dec_wr_en   = (w_funct != FN_JR) && (if_instr != 32'h0);
         w_dec_wr_addr = w_rd;
      end else if (is_itype_alu(w_opcode) || (w_opcode == OP_LW)) begin
         w_dec_wr_en   = 1'b1;
         w_dec_wr_addr = w_rt;
      end else if (w_opcode == OP_JAL) begin
         w_dec_wr_en   = 1'b1;
         w_dec_wr_addr = REG_RA;
      end
      if (!w_dec_wr_en)
         w_dec_wr_addr = '0;
   end

   // Immediate: logical ops zero-extend, LUI shifts up, everything else sign-extends
   always_comb begin
      w_dec_imm = {{16{w_imm16[15]}}, w_imm16};
      if ((w_opcode == OP_ANDI) || (w_opcode == OP_ORI) || (w_opcode == OP_XORI))
         w_dec_imm = {16'h0, w_imm16};
      else if (w_opcode == OP_LUI)
         w_dec_imm = {w_imm16, 16'h0};
   end

   // A load's data is not available in EX, so it never feeds the bypass
   assign w_ex_fwd_en = ex_wr_en && !ex_is_load;

   fwd_mux u_fwd_rs (
      .addr     (w_rs),
      .rf_data  (rf_rd_dataA),
      .ex_en    (w_ex_fwd_en),
      .ex_addr  (ex_wr_addr),
      .ex_data  (ex_fwd_data),
      .mem_en   (mem_wr_en),
      .mem_addr (mem_wr_addr),
      .mem_data (mem_wr_data),
      .wb_en    (wb_wr_en),
      .wb_addr  (wb_wr_addr),
      .wb_data  (wb_wr_data),
      .operand  (w_opA)
   );

   fwd_mux u_fwd_rt (
      .addr     (w_rt),
      .rf_data  (rf_rd_dataB),
      .ex_en    (w_ex_fwd_en),
      .ex_addr  (ex_wr_addr),
      .ex_data  (ex_fwd_data),
      .mem_en   (mem_wr_en),
      .mem_addr (mem_wr_addr),
      .mem_data (mem_wr_data),
      .wb_en    (wb_wr_en),
      .wb_addr  (wb_wr_addr),
      .wb_data  (wb_wr_data),
      .operand  (w_opB)
   );

   // Load-use hazard: the consumer needs a value that is still being loaded
   always_comb begin
      w_load_use = if_valid && ex_wr_en && ex_is_load && (ex_wr_addr != '0) &&
                   ((w_use_rs && (w_rs == ex_wr_addr)) ||
                    (w_use_rt && (w_rt == ex_wr_addr)));
      id_stall   = !flush && (ex_hold || w_load_use);
   end

   // Assemble the decoded ID/EX word for the instruction currently in ID
   always_comb begin
      w_dec         = '0;
      w_dec.valid   = if_valid;
      w_dec.pc      = if_pc;
      w_dec.opcode  = w_opcode;
      w_dec.funct   = w_funct;
      w_dec.opA     = w_opA;
      w_dec.opB     = w_opB;
      w_dec.imm     = w_dec_imm;
      w_dec.wr_en   = w_dec_wr_en && if_valid;
      w_dec.wr_addr = w_dec_wr_addr;
      w_dec.is_load = (w_opcode == OP_LW) && if_valid;
   end

   // ID/EX register: reset, flush, hold, bubble, then normal advance
   always_ff @(posedge clk) begin
      if (!nrst) begin
         r_idex <= '0;
      end else if (flush) begin
         r_idex <= '0;
      end else if (ex_hold) begin
         r_idex <= r_idex;
      end else if (w_load_use) begin
         r_idex         <= w_dec;
         r_idex.valid   <= 1'b0;
         r_idex.wr_en   <= 1'b0;
         r_idex.is_load <= 1'b0;
      end else begin
         r_idex <= w_dec;
      end
   end

   assign idex_valid   = r_idex.valid;
   assign idex_pc      = r_idex.pc;
   assign idex_opcode  = r_idex.opcode;
   assign idex_funct   = r_idex.funct;
   assign idex_opA     = r_idex.opA;
   assign idex_opB     = r_idex.opB;
   assign idex_imm     = r_idex.imm;
   assign idex_wr_en   = r_idex.wr_en;
   assign idex_wr_addr = r_idex.wr_addr;
   assign idex_is_load = r_idex.is_load;

endmodule : id_operand_stage
`default_nettype wire

// File: tb/tb_id_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_operand_stage
//  Description : Scoreboard bench for id_operand_stage with a behavioural
//                reference model, directed scenarios and random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_operand_stage;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        nrst, if_valid;
   logic [31:0] if_instr, if_pc;
   logic        id_stall;
   logic [4:0]  rf_rd_addrA, rf_rd_addrB;
   logic [31:0] rf_rd_dataA, rf_rd_dataB;
   logic        ex_wr_en, ex_is_load;
   logic [4:0]  ex_wr_addr;
   logic [31:0] ex_fwd_data;
   logic        mem_wr_en;
   logic [4:0]  mem_wr_addr;
   logic [31:0] mem_wr_data;
   logic        wb_wr_en;
   logic [4:0]  wb_wr_addr;
   logic [31:0] wb_wr_data;
   logic        ex_hold, flush;
   logic        idex_valid;
   logic [31:0] idex_pc;
   logic [5:0]  idex_opcode, idex_funct;
   logic [31:0] idex_opA, idex_opB, idex_imm;
   logic        idex_wr_en;
   logic [4:0]  idex_wr_addr;
   logic        idex_is_load;

   // Register file contents seen by the stage (static during the run)
   logic [31:0] rf [32];
   assign rf_rd_dataA = rf[rf_rd_addrA];
   assign rf_rd_dataB = rf[rf_rd_addrB];

   id_operand_stage dut (
      .clk(clk), .nrst(nrst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
      .id_stall(id_stall), .rf_rd_addrA(rf_rd_addrA), .rf_rd_addrB(rf_rd_addrB),
      .rf_rd_dataA(rf_rd_dataA), .rf_rd_dataB(rf_rd_dataB),
      .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load), .ex_wr_addr(ex_wr_addr),
      .ex_fwd_data(ex_fwd_data), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
      .mem_wr_data(mem_wr_data), .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr),
      .wb_wr_data(wb_wr_data), .ex_hold(ex_hold), .flush(flush),
      .idex_valid(idex_valid), .idex_pc(idex_pc), .idex_opcode(idex_opcode),
      .idex_funct(idex_funct), .idex_opA(idex_opA), .idex_opB(idex_opB),
      .idex_imm(idex_imm), .idex_wr_en(idex_wr_en), .idex_wr_addr(idex_wr_addr),
      .idex_is_load(idex_is_load)
   );

   // Expected ID/EX word; 'care' = 0 means only valid/wr_en/is_load are defined
   typedef struct {
      logic        valid;
      logic [31:0] pc;
      logic [5:0]  opcode;
      logic [5:0]  funct;
      logic [31:0] opA;
      logic [31:0] opB;
      logic [31:0] imm;
      logic        wr_en;
      logic [4:0]  wr_addr;
      logic        is_load;
      logic        care;
   } exp_t;

   exp_t sb[$];
   exp_t st;
   int   tests = 0;
   int   fails = 0;

   logic [5:0] ops [15];
   logic [5:0] fns [6];

   function automatic exp_t zero_word();
      exp_t z;
      z.valid = 0; z.pc = 0; z.opcode = 0; z.funct = 0; z.opA = 0; z.opB = 0;
      z.imm = 0; z.wr_en = 0; z.wr_addr = 0; z.is_load = 0; z.care = 1;
      return z;
   endfunction

   // Reference value of a source register as seen by the instruction in ID
   function automatic logic [31:0] resolve(input logic [4:0] a);
      if (a == 0) return 32'h0;
      if (ex_wr_en && !ex_is_load && ex_wr_addr == a) return ex_fwd_data;
      if (mem_wr_en && mem_wr_addr == a) return mem_wr_data;
      if (wb_wr_en && wb_wr_addr == a) return wb_wr_data;
      return rf[a];
   endfunction

   // Settle, check combinational outputs, predict next ID/EX word, advance
   task automatic step();
      exp_t        nx;
      logic [5:0]  op, fn;
      logic [4:0]  rs, rt, rd, dst;
      logic        use_rs, use_rt, lu, exp_stall, writes;
      logic [15:0] i16;
      #1;
      op = if_instr[31:26]; rs = if_instr[25:21]; rt = if_instr[20:16];
      rd = if_instr[15:11]; fn = if_instr[5:0];   i16 = if_instr[15:0];
      use_rs = !(op inside {6'h0F, 6'h02, 6'h03});
      use_rt = op inside {6'h00, 6'h2B, 6'h04, 6'h05};
      lu = if_valid && ex_wr_en && ex_is_load && ex_wr_addr != 0 &&
           ((use_rs && rs == ex_wr_addr) || (use_rt && rt == ex_wr_addr));
      exp_stall = !flush && (ex_hold || lu);
      tests++;
      if (id_stall !== exp_stall || rf_rd_addrA !== rs || rf_rd_addrB !== rt) begin
         fails++;
         $display("FAIL comb @%0t: stall=%b addrA=%0d addrB=%0d, expected stall=%b addrA=%0d addrB=%0d",
                  $time, id_stall, rf_rd_addrA, rf_rd_addrB, exp_stall, rs, rt);
      end

      writes = 0; dst = 0;
      if (op == 6'h00)                          begin writes = (fn != 6'h08) && (if_instr != 0); dst = rd; end
      else if ((op >= 6'h08 && op <= 6'h0F) || op == 6'h23) begin writes = 1; dst = rt; end
      else if (op == 6'h03)                     begin writes = 1; dst = 5'd31; end
      if (!writes) dst = 0;

      if (!nrst || flush) begin
         nx = zero_word();
      end else if (ex_hold) begin
         nx = st;
      end else begin
         nx.valid   = if_valid;
         nx.pc      = if_pc;
         nx.opcode  = op;
         nx.funct   = fn;
         nx.opA     = resolve(rs);
         nx.opB     = resolve(rt);
         if (op inside {6'h0C, 6'h0D, 6'h0E}) nx.imm = {16'h0, i16};
         else if (op == 6'h0F)                nx.imm = {i16, 16'h0};
         else                                 nx.imm = 32'($signed(i16));
         nx.wr_en   = writes && if_valid;
         nx.wr_addr = dst;
         nx.is_load = (op == 6'h23) && if_valid;
         nx.care    = 1;
         if (lu) begin
            nx.valid = 0; nx.wr_en = 0; nx.is_load = 0; nx.care = 0;
         end
      end
      sb.push_back(nx);
      st = nx;
      @(negedge clk);
   endtask

   // Monitor: after every active edge compare the ID/EX outputs with the next prediction
   initial begin
      exp_t e;
      logic bad;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            tests++;
            bad = (idex_valid !== e.valid) || (idex_wr_en !== e.wr_en) || (idex_is_load !== e.is_load);
            if (e.care)
               bad = bad || (idex_pc !== e.pc) || (idex_opcode !== e.opcode) ||
                     (idex_funct !== e.funct) || (idex_opA !== e.opA) || (idex_opB !== e.opB) ||
                     (idex_imm !== e.imm) || (idex_wr_addr !== e.wr_addr);
            if (bad) begin
               fails++;
               $display("FAIL idex @%0t: got v=%b pc=%h op=%h fn=%h A=%h B=%h imm=%h we=%b wa=%0d ld=%b; expected v=%b pc=%h op=%h fn=%h A=%h B=%h imm=%h we=%b wa=%0d ld=%b (full=%b)",
                        $time, idex_valid, idex_pc, idex_opcode, idex_funct, idex_opA, idex_opB,
                        idex_imm, idex_wr_en, idex_wr_addr, idex_is_load,
                        e.valid, e.pc, e.opcode, e.funct, e.opA, e.opB, e.imm, e.wr_en,
                        e.wr_addr, e.is_load, e.care);
            end
         end
      end
   end

   task automatic idle();
      nrst = 1; if_valid = 0; if_instr = 0; if_pc = 0;
      ex_wr_en = 0; ex_is_load = 0; ex_wr_addr = 0; ex_fwd_data = 0;
      mem_wr_en = 0; mem_wr_addr = 0; mem_wr_data = 0;
      wb_wr_en = 0; wb_wr_addr = 0; wb_wr_data = 0;
      ex_hold = 0; flush = 0;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [5:0] op;
      if ($urandom_range(0, 99) < 5) return 32'h0;
      op = ops[$urandom_range(0, 14)];
      if (op == 6'h00)
         return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 31)), fns[$urandom_range(0, 5)]};
      return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
   endfunction

   initial begin
      ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
              6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h06};
      fns = '{6'h20, 6'h21, 6'h22, 6'h24, 6'h25, 6'h08};
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      rf[0] = 32'hDEAD_BEEF;
      rf[1] = 32'd5;
      rf[2] = 32'd7;
      idle();
      nrst = 0;
      @(negedge clk);

      // Reset
      step(); step();
      idle();

      // ADD r3,r1,r2 with no hazards
      if_valid = 1; if_pc = 32'h100; if_instr = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}; step();

      // Forward priority on rs=r4
      if_instr = {6'h00, 5'd4, 5'd0, 5'd5, 5'd0, 6'h20}; if_pc = 32'h104;
      ex_wr_en = 1;  ex_wr_addr = 4;  ex_fwd_data = 32'hAA;
      mem_wr_en = 1; mem_wr_addr = 4; mem_wr_data = 32'hBB;
      wb_wr_en = 1;  wb_wr_addr = 4;  wb_wr_data = 32'hCC;
      step();
      ex_wr_en = 0;  step();
      mem_wr_en = 0; step();
      idle();

      // Load-use: LW r8 in EX, ADDI r9,r8,1 in ID; then load forwarded from MEM
      if_valid = 1; if_pc = 32'h200; if_instr = {6'h08, 5'd8, 5'd9, 16'd1};
      ex_wr_en = 1; ex_is_load = 1; ex_wr_addr = 8;
      step();
      ex_wr_en = 0; ex_is_load = 0; mem_wr_en = 1; mem_wr_addr = 8; mem_wr_data = 32'h10;
      step();
      idle();

      // Register zero and LUI not stalling on an rs match
      if_valid = 1; if_instr = {6'h08, 5'd0, 5'd6, 16'hFFFF};
      wb_wr_en = 1; wb_wr_addr = 0; wb_wr_data = 32'hFFFF;
      step();
      idle();
      if_valid = 1; if_instr = {6'h0F, 5'd8, 5'd10, 16'h1234};
      ex_wr_en = 1; ex_is_load = 1; ex_wr_addr = 8;
      step();
      idle();

      // Flush beats hold; then hold alone for three cycles
      if_valid = 1; if_instr = {6'h00, 5'd1, 5'd2, 5'd7, 5'd0, 6'h22}; step();
      flush = 1; ex_hold = 1; step();
      flush = 0; ex_hold = 0; step();
      ex_hold = 1; if_instr = {6'h0D, 5'd2, 5'd3, 16'h8001};
      step(); step(); step();
      idle();

      // Reset during a load-use stall, then a normal instruction
      if_valid = 1; if_instr = {6'h08, 5'd8, 5'd9, 16'd1};
      ex_wr_en = 1; ex_is_load = 1; ex_wr_addr = 8; nrst = 0;
      step();
      idle();
      if_valid = 1; if_pc = 32'h300; if_instr = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20};
      step();

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         nrst        = ($urandom_range(0, 99) >= 3);
         if_valid    = ($urandom_range(0, 99) < 85);
         if_instr    = rand_instr();
         if_pc       = $urandom;
         ex_wr_en    = 1'($urandom_range(0, 1));
         ex_is_load  = ($urandom_range(0, 99) < 40);
         ex_wr_addr  = 5'($urandom_range(0, 7));
         ex_fwd_data = $urandom;
         mem_wr_en   = 1'($urandom_range(0, 1));
         mem_wr_addr = 5'($urandom_range(0, 7));
         mem_wr_data = $urandom;
         wb_wr_en    = 1'($urandom_range(0, 1));
         wb_wr_addr  = 5'($urandom_range(0, 7));
         wb_wr_data  = $urandom;
         ex_hold     = ($urandom_range(0, 99) < 15);
         flush       = ($urandom_range(0, 99) < 8);
         step();
      end
      idle();

      @(negedge clk);
      @(negedge clk);
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d predictions left unchecked, expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_id_operand_stage
`default_nettype wire
